// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes,
// controller states and a small decode helper.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MULT  = 3'b000,
        MULTU = 3'b001,
        DIV   = 3'b010,
        DIVU  = 3'b011,
        MTHI  = 3'b100,
        MTLO  = 3'b101
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // True for the operations that run through the iterative datapath.
    function automatic logic is_iter_op(input muldiv_op_t o);
        return (o == MULT) || (o == MULTU) || (o == DIV) || (o == DIVU);
    endfunction

    // True for the operations that work on two's complement operands.
    function automatic logic is_signed_op(input muldiv_op_t o);
        return (o == MULT) || (o == DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// Combinational W-bit add/subtract step shared by the multiply (add) and
// divide (subtract) iterations. carry is the adder carry-out; in subtract
// mode carry=1 means "no borrow", i.e. x >= y.
module muldiv_step #(
    parameter int W = 33
) (
    input  logic         mode,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] sum,
    output logic         carry
);

    logic [W:0] full;

    // Two's complement subtract as x + ~y + 1 when mode is set.
    always_comb begin
        full = {1'b0, x} + {1'b0, y ^ {W{mode}}} + {{W{1'b0}}, mode};
    end

    assign sum   = full[W-1:0];
    assign carry = full[W];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
// Handshake: start is a one-cycle strobe honoured only while the controller
// is IDLE (ignored otherwise); busy is high for the whole N+1-cycle
// operation; done pulses for one cycle in the cycle where hi/lo first show
// the new mult/div result. MTHI/MTLO complete at the accepting edge.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         div_by_zero,
    output state_t       dbg_state
);

    localparam int CNT_W = $clog2(N);

    muldiv_op_t op_in;
    assign op_in = muldiv_op_t'(op);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     work_hi_q, work_hi_d;   // multiply: product high / divide: remainder
    logic [N-1:0]     work_lo_q, work_lo_d;   // multiply: multiplier+product low / divide: dividend->quotient
    logic [N-1:0]     opnd_q, opnd_d;         // multiplicand or divisor magnitude
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;           // product/quotient must be negated
    logic             sign_a_q, sign_a_d;     // remainder takes the dividend sign
    logic             bzero_q, bzero_d;
    logic [N-1:0]     hi_q, hi_d;
    logic [N-1:0]     lo_q, lo_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    // Operand sign/magnitude preparation for a starting operation.
    logic         a_neg, b_neg;
    logic [N-1:0] a_mag, b_mag;

    always_comb begin
        a_neg = is_signed_op(op_in) & a[N-1];
        b_neg = is_signed_op(op_in) & b[N-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    // Shared adder: add for multiply, restoring subtract for divide.
    logic [N:0] step_x, step_y, step_sum;
    logic       step_carry;

    always_comb begin
        step_x = is_div_q ? {work_hi_q, work_lo_q[N-1]} : {1'b0, work_hi_q};
        step_y = {1'b0, opnd_q};
    end

    muldiv_step #(.W(N + 1)) u_step (
        .mode  (is_div_q),
        .x     (step_x),
        .y     (step_y),
        .sum   (step_sum),
        .carry (step_carry)
    );

    // Sign correction applied when leaving the iteration.
    logic [2*N-1:0] prod_raw, prod_fix;
    logic [N-1:0]   quo_fix, rem_fix;

    always_comb begin
        prod_raw = {work_hi_q, work_lo_q};
        prod_fix = neg_q ? -prod_raw : prod_raw;
        quo_fix  = bzero_q ? '1 : (neg_q ? -work_lo_q : work_lo_q);
        rem_fix  = sign_a_q ? -work_hi_q : work_hi_q;
    end

    // Controller and datapath next-state logic.
    logic [N:0] mul_acc;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        sign_a_d  = sign_a_q;
        bzero_d   = bzero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;
        mul_acc   = work_lo_q[0] ? step_sum : {1'b0, work_hi_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_iter_op(op_in)) begin
                        is_div_d  = op_in[1];
                        neg_d     = a_neg ^ b_neg;
                        sign_a_d  = a_neg;
                        bzero_d   = (b == '0);
                        work_hi_d = '0;
                        work_lo_d = op_in[1] ? a_mag : b_mag;
                        opnd_d    = op_in[1] ? b_mag : a_mag;
                        cnt_d     = CNT_W'(N - 1);
                        dbz_d     = 1'b0;
                        state_d   = CALC;
                    end else if (op_in == MTHI) begin
                        hi_d  = a;
                        dbz_d = 1'b0;
                    end else if (op_in == MTLO) begin
                        lo_d  = a;
                        dbz_d = 1'b0;
                    end
                end
            end
            CALC: begin
                if (is_div_q) begin
                    // Restoring step: keep the difference only if no borrow.
                    work_hi_d = step_carry ? step_sum[N-1:0] : step_x[N-1:0];
                    work_lo_d = {work_lo_q[N-2:0], step_carry};
                end else begin
                    // Shift-add step: conditionally add, then shift the 2N-bit product right.
                    work_hi_d = mul_acc[N:1];
                    work_lo_d = {mul_acc[0], work_lo_q[N-1:1]};
                end
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                if (is_div_q) begin
                    lo_d  = quo_fix;
                    hi_d  = rem_fix;
                    dbz_d = bzero_q;
                end else begin
                    hi_d = prod_fix[2*N-1:N];
                    lo_d = prod_fix[N-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            sign_a_q  <= 1'b0;
            bzero_q   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            sign_a_q  <= sign_a_d;
            bzero_q   <= bzero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (N=32): directed scenarios plus
// randomized operations checked against a plain-arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [2:0]    op;
    logic [N-1:0]  a, b;
    logic          busy, done, div_by_zero;
    logic [N-1:0]  hi, lo;
    state_t        dbg_state;

    int checks = 0;
    int failures = 0;

    // Reference architectural state.
    logic [N-1:0] m_hi = '0;
    logic [N-1:0] m_lo = '0;
    logic         m_dbz = 1'b0;

    muldiv_unit #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model: architectural effect of one accepted operation.
    task automatic model_apply(input logic [2:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
        logic signed [63:0] sx, sy, sp, sq, sr;
        logic [63:0] up;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        case (o)
            3'b000: begin sp = sx * sy; m_hi = sp[63:32]; m_lo = sp[31:0]; m_dbz = 1'b0; end
            3'b001: begin up = {32'd0, x} * {32'd0, y}; m_hi = up[63:32]; m_lo = up[31:0]; m_dbz = 1'b0; end
            3'b010, 3'b011: begin
                if (y == 0) begin
                    m_lo = '1; m_hi = x; m_dbz = 1'b1;
                end else if (o == 3'b010) begin
                    sq = sx / sy; sr = sx % sy;
                    m_lo = sq[31:0]; m_hi = sr[31:0]; m_dbz = 1'b0;
                end else begin
                    m_lo = x / y; m_hi = x % y; m_dbz = 1'b0;
                end
            end
            3'b100: begin m_hi = x; m_dbz = 1'b0; end
            3'b101: begin m_lo = x; m_dbz = 1'b0; end
            default: begin end
        endcase
    endtask

    // Driver: present one start strobe; returns 1 time unit after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Waits (bounded) for done; cyc = edges after the start edge, -1 on timeout.
    task automatic wait_done(output int cyc, output int busy_low);
        cyc = -1;
        busy_low = 0;
        for (int i = 1; i <= 100; i++) begin
            if (!busy) busy_low++;
            @(posedge clk); #1;
            if (done) begin cyc = i; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (hi !== '0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== '0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
        checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
        checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_multu_max();
        int cyc, bl;
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        model_apply(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(cyc, bl);
        checks++; if (cyc !== N + 1) begin failures++; $display("FAIL multu_latency got=%0d exp=%0d", cyc, N + 1); end
        checks++; if (bl !== 0) begin failures++; $display("FAIL multu_busy_low got=%0d exp=0", bl); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL multu_busy_at_done got=%b exp=0", busy); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_hi got=%h exp=fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin failures++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL multu_done_width got=%b exp=0", done); end
    endtask

    task automatic test_back_to_back();
        int cyc, bl;
        issue(3'b000, 32'hFFFF_FFFD, 32'd7);
        model_apply(3'b000, 32'hFFFF_FFFD, 32'd7);
        wait_done(cyc, bl);
        checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_neg_hi got=%h exp=ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mult_neg_lo got=%h exp=ffffffeb", lo); end
        // Issued from the done cycle.
        issue(3'b010, 32'hFFFF_FFF9, 32'd2);
        model_apply(3'b010, 32'hFFFF_FFF9, 32'd2);
        wait_done(cyc, bl);
        checks++; if (cyc !== N + 1) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", cyc, N + 1); end
        checks++; if (lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_neg_lo got=%h exp=fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_neg_hi got=%h exp=ffffffff", hi); end
    endtask

    task automatic test_div_by_zero();
        int cyc, bl, dones;
        issue(3'b011, 32'd100, 32'd0);
        model_apply(3'b011, 32'd100, 32'd0);
        wait_done(cyc, bl);
        checks++; if (cyc !== N + 1) begin failures++; $display("FAIL dbz_latency got=%0d exp=%0d", cyc, N + 1); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL dbz_lo got=%h exp=ffffffff", lo); end
        checks++; if (hi !== 32'h0000_0064) begin failures++; $display("FAIL dbz_hi got=%h exp=00000064", hi); end
        checks++; if (div_by_zero !== 1'b1) begin failures++; $display("FAIL dbz_flag got=%b exp=1", div_by_zero); end
        issue(3'b101, 32'd5, 32'd0);
        model_apply(3'b101, 32'd5, 32'd0);
        checks++; if (lo !== 32'd5) begin failures++; $display("FAIL mtlo_lo got=%h exp=00000005", lo); end
        checks++; if (hi !== 32'h0000_0064) begin failures++; $display("FAIL mtlo_hi_kept got=%h exp=00000064", hi); end
        checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL mtlo_dbz got=%b exp=0", div_by_zero); end
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            if (done || busy) dones++;
            @(posedge clk); #1;
        end
        checks++; if (dones !== 0) begin failures++; $display("FAIL mtlo_no_done got=%0d exp=0", dones); end
    endtask

    task automatic test_div_overflow();
        int cyc, bl;
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        model_apply(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc, bl);
        checks++; if (lo !== 32'h8000_0000) begin failures++; $display("FAIL ovf_lo got=%h exp=80000000", lo); end
        checks++; if (hi !== 32'h0000_0000) begin failures++; $display("FAIL ovf_hi got=%h exp=00000000", hi); end
        checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL ovf_dbz got=%b exp=0", div_by_zero); end
    endtask

    task automatic test_start_while_busy();
        int cyc, bl;
        issue(3'b011, 32'd50, 32'd7);
        model_apply(3'b011, 32'd50, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 3'b001; a = 32'd3; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc, bl);
        checks++; if (cyc !== N + 1 - 10) begin failures++; $display("FAIL busy_start_latency got=%0d exp=%0d", cyc, N + 1 - 10); end
        checks++; if (lo !== 32'd7) begin failures++; $display("FAIL busy_start_lo got=%h exp=00000007", lo); end
        checks++; if (hi !== 32'd1) begin failures++; $display("FAIL busy_start_hi got=%h exp=00000001", hi); end
    endtask

    task automatic test_async_reset();
        int cyc, bl, activity;
        issue(3'b000, 32'h0001_2345, 32'hFFFF_0001);
        repeat (15) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        m_hi = '0; m_lo = '0; m_dbz = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL areset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL areset_done got=%b exp=0", done); end
        checks++; if (hi !== '0) begin failures++; $display("FAIL areset_hi got=%h exp=0", hi); end
        checks++; if (lo !== '0) begin failures++; $display("FAIL areset_lo got=%h exp=0", lo); end
        @(negedge clk);
        reset = 1'b0;
        activity = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) activity++;
        end
        checks++; if (activity !== 0) begin failures++; $display("FAIL areset_no_resume got=%0d exp=0", activity); end
        issue(3'b001, 32'd6, 32'd7);
        model_apply(3'b001, 32'd6, 32'd7);
        wait_done(cyc, bl);
        checks++; if (cyc !== N + 1) begin failures++; $display("FAIL post_reset_latency got=%0d exp=%0d", cyc, N + 1); end
        checks++; if (lo !== 32'd42) begin failures++; $display("FAIL post_reset_lo got=%h exp=0000002a", lo); end
        checks++; if (hi !== 32'd0) begin failures++; $display("FAIL post_reset_hi got=%h exp=00000000", hi); end
    endtask

    task automatic test_random();
        int cyc, bl;
        logic [2:0] o;
        logic [N-1:0] x, y;
        for (int it = 0; it < 48; it++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = '0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: begin x = 32'($urandom_range(0, 300)); y = 32'($urandom_range(1, 20)); end
                3: y = {{28{y[31]}}, y[3:0]};
                default: begin end
            endcase
            issue(o, x, y);
            model_apply(o, x, y);
            if (o[2] == 1'b0) begin
                wait_done(cyc, bl);
                checks++; if (cyc !== N + 1) begin failures++; $display("FAIL rand_latency op=%0d got=%0d exp=%0d", o, cyc, N + 1); end
            end else begin
                checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rand_ctl op=%0d busy=%b done=%b exp=0/0", o, busy, done); end
            end
            checks++; if (hi !== m_hi) begin failures++; $display("FAIL rand_hi op=%0d a=%h b=%h got=%h exp=%h", o, x, y, hi, m_hi); end
            checks++; if (lo !== m_lo) begin failures++; $display("FAIL rand_lo op=%0d a=%h b=%h got=%h exp=%h", o, x, y, lo, m_lo); end
            checks++; if (div_by_zero !== m_dbz) begin failures++; $display("FAIL rand_dbz op=%0d got=%b exp=%b", o, div_by_zero, m_dbz); end
        end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_back_to_back();
        test_div_by_zero();
        test_div_overflow();
        test_start_while_busy();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
